fsmc_bus_arbiter: RTL

// Shares one single-port internal register/memory port between the external FSMC host
// (async SRAM-style strobes) and one internal fabric requester. Synchronises FSMC strobes

---
 rtl/fsmc_bus_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fsmc_bus_arbiter.sv
// Arbitrates one single-port memory between an FSMC async host and an internal requester.
// Optional macro FSMC_ARB_RR_EN selects round-robin instead of fixed FSMC priority.
module fsmc_bus_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] fsmc_a,
    input  logic [DW-1:0] fsmc_d_in,
    output logic [DW-1:0] fsmc_d_out,
    output logic          fsmc_d_oe,
    input  logic          fsmc_ne1,
    input  logic          fsmc_nwe,
    input  logic          fsmc_noe,
    input  logic          fsmc_nbl1,
    input  logic          fsmc_nbl0,
    input  logic          int_req,
    input  logic          int_we,
    input  logic [AW-1:0] int_addr,
    input  logic [DW-1:0] int_wdata,
    output logic          int_gnt,
    output logic          int_rvalid,
    output logic [DW-1:0] int_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {
        StIdle, StFWr, StFRd, StFRdHold, StIAcc, StIRdw
    } state_e;

    state_e        state_q, state_d;
    // Strobe synchronisers, bit order {ne1, nwe, noe}; reset inactive (high).
    logic [2:0]    sync1_q, sync2_q;
    logic          wr_act_q, rd_act_q;
    logic          pend_q, pend_d;
    logic          cap_wr_q, cap_wr_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [DW-1:0] cap_data_q, cap_data_d;
    logic [1:0]    cap_nbl_q, cap_nbl_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic          d_oe_q, d_oe_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wr_act, rd_act, wr_rise, rd_rise, any_rise, fsmc_req, fsmc_first;
`ifdef FSMC_ARB_RR_EN
    logic          last_fsmc_q, last_fsmc_d;
`endif

    assign wr_act   = ~sync2_q[2] & ~sync2_q[1];
    assign rd_act   = ~sync2_q[2] & ~sync2_q[0];
    assign wr_rise  = wr_act & ~wr_act_q;
    assign rd_rise  = rd_act & ~rd_act_q;
    assign any_rise = wr_rise | rd_rise;
    assign fsmc_req = pend_q | any_rise;

`ifdef FSMC_ARB_RR_EN
    assign fsmc_first = fsmc_req & ~(int_req & last_fsmc_q);
`else
    assign fsmc_first = fsmc_req;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cap_wr_d   = cap_wr_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_nbl_d  = cap_nbl_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 2'b00;
        mem_addr   = '0;
        mem_wdata  = '0;
        int_gnt    = 1'b0;
`ifdef FSMC_ARB_RR_EN
        last_fsmc_d = last_fsmc_q;
`endif
        // A simultaneous write and read strobe edge is served as a write.
        if (any_rise) begin
            pend_d     = 1'b1;
            cap_wr_d   = wr_rise;
            cap_addr_d = fsmc_a;
            cap_data_d = fsmc_d_in;
            cap_nbl_d  = {fsmc_nbl1, fsmc_nbl0};
        end
        case (state_q)
            StIdle: begin
                if (fsmc_first) begin
                    state_d = (any_rise ? wr_rise : cap_wr_q) ? StFWr : StFRd;
                    pend_d  = 1'b0;
`ifdef FSMC_ARB_RR_EN
                    last_fsmc_d = 1'b1;
`endif
                end else if (int_req) begin
                    state_d = StIAcc;
`ifdef FSMC_ARB_RR_EN
                    last_fsmc_d = 1'b0;
`endif
                end
            end
            StFWr: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = ~cap_nbl_q;
                mem_addr  = cap_addr_q;
                mem_wdata = cap_data_q;
                state_d   = StIdle;
            end
            StFRd: begin
                mem_en   = 1'b1;
                mem_be   = 2'b11;
                mem_addr = cap_addr_q;
                state_d  = StFRdHold;
            end
            StFRdHold: begin
                // First cycle here (oe still low) is when the memory data is valid.
                if (!d_oe_q) begin
                    d_out_d = mem_rdata;
                    d_oe_d  = 1'b1;
                end else if (!rd_act) begin
                    d_oe_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StIAcc: begin
                mem_en    = 1'b1;
                mem_we    = int_we;
                mem_be    = 2'b11;
                mem_addr  = int_addr;
                mem_wdata = int_wdata;
                int_gnt   = 1'b1;
                state_d   = int_we ? StIdle : StIRdw;
            end
            StIRdw: begin
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            wr_act_q   <= 1'b0;
            rd_act_q   <= 1'b0;
            pend_q     <= 1'b0;
            cap_wr_q   <= 1'b0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_nbl_q  <= 2'b11;
            d_out_q    <= '0;
            d_oe_q     <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
`ifdef FSMC_ARB_RR_EN
            last_fsmc_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= {fsmc_ne1, fsmc_nwe, fsmc_noe};
            sync2_q    <= sync1_q;
            wr_act_q   <= wr_act;
            rd_act_q   <= rd_act;
            pend_q     <= pend_d;
            cap_wr_q   <= cap_wr_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_nbl_q  <= cap_nbl_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef FSMC_ARB_RR_EN
            last_fsmc_q <= last_fsmc_d;
`endif
        end
    end

    assign fsmc_d_out = d_out_q;
    assign fsmc_d_oe  = d_oe_q;
    assign int_rdata  = rdata_q;
    assign int_rvalid = rvalid_q;
    assign busy       = (state_q != StIdle) | pend_q;

endmodule
